// File: rtl/uart_rx_if.sv
// uart_rx_if -- serial line plus received-byte signals of the UART receiver.
//   rx       : serial line, idle high, 8N1, LSB first (driven by master)
//   rx_d     : last correctly framed byte
//   rx_valid : one-cycle pulse, rx_d is new in that cycle
//   rx_err   : one-cycle pulse on a framing error
//   rx_busy  : receiver is not idle
// master: line driver / byte consumer side; slave: the receiver.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_d;
    logic       rx_valid;
    logic       rx_err;
    logic       rx_busy;

    modport master (output rx, input rx_d, rx_valid, rx_err, rx_busy);
    modport slave  (input rx, output rx_d, rx_valid, rx_err, rx_busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver, LSB first, mid-bit sampling.
//   CLKS_PER_BIT : clk_125MHz cycles per bit period (8..65535)
//   clk_125MHz   : single clock, all state on its rising edge
//   rst          : asynchronous, active-high reset
//   bus          : uart_rx_if.slave (rx in; rx_d, rx_valid, rx_err, rx_busy out)
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 1085
) (
    input  logic      clk_125MHz,
    input  logic      rst,
    uart_rx_if.slave  bus
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shift;
    logic        rx_m;
    logic        rx_s;
    logic [7:0]  rx_d_q;
    logic        rx_valid_q;
    logic        rx_err_q;
    logic        rx_busy_q;

    assign bus.rx_d     = rx_d_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_err   = rx_err_q;
    assign bus.rx_busy  = rx_busy_q;

    // Two-flop synchronizer, preset to the idle level so reset never looks
    // like a start bit.
    always_ff @(posedge clk_125MHz or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
        end
    end

    // rx_busy is registered alongside each state change so it always
    // reflects the state being entered.
    always_ff @(posedge clk_125MHz or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            rx_d_q     <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_busy_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state     <= START;
                        cnt       <= '0;
                        rx_busy_q <= 1'b1;
                    end
                end
                START: begin
                    // Half a bit after the edge: confirm the start bit so the
                    // rest of the samples land at mid-bit.
                    if (cnt == HALF_M1) begin
                        if (rx_s) begin
                            state     <= IDLE;
                            rx_busy_q <= 1'b0;
                        end else begin
                            state <= DATA;
                            cnt   <= '0;
                            idx   <= '0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_M1) begin
                        shift <= {rx_s, shift[7:1]};
                        cnt   <= '0;
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_d_q     <= shift;
                            rx_valid_q <= 1'b1;
                            state      <= IDLE;
                            rx_busy_q  <= 1'b0;
                        end else begin
                            rx_err_q <= 1'b1;
                            state    <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line (break) must not be taken as a new start bit.
                    if (rx_s) begin
                        state     <= IDLE;
                        rx_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1085, clk_125MHz cycles per bit period (115200 baud at 125 MHz); legal range 8..65535.
REQ-002 SHALL have port clk_125MHz  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-005 SHALL have port rx_d  output  8  last correctly framed byte; holds until the next good frame.
REQ-006 SHALL have port rx_valid  output  1  one-cycle pulse; rx_d is new in that cycle.
REQ-007 SHALL have port rx_err  output  1  one-cycle pulse on a framing error (stop bit sampled 0).
REQ-008 SHALL have port rx_busy  output  1  high in every state other than IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer (preset to 1); all logic uses the synchronized bit rx_s only.
REQ-010 SHALL implement the states IDLE, START, DATA, STOP and WAIT_IDLE, plus a 16-bit bit-time counter and a 3-bit bit index.
REQ-011 IDLE: when rx_s = 0, SHALL enter START with counter = 0; otherwise stay in IDLE.
REQ-012 START: counter increments each cycle; at counter = CLKS_PER_BIT/2 - 1 (integer divide), SHALL sample rx_s.
REQ-013 START sample = 1 (glitch): SHALL return to IDLE with no rx_valid or rx_err pulse.
REQ-014 START sample = 0: SHALL clear counter and bit index and enter DATA.
REQ-015 DATA: at counter = CLKS_PER_BIT - 1, SHALL shift rx_s into shift[7] (right shift, LSB first), clear counter and increment bit index.
REQ-016 DATA: after the sample taken at bit index 7, SHALL enter STOP.
REQ-017 All samples after the start bit SHALL fall at mid-bit, offset CLKS_PER_BIT/2 from the detected falling edge.
REQ-018 STOP: at counter = CLKS_PER_BIT - 1, SHALL sample rx_s.
REQ-019 STOP sample = 1: SHALL load rx_d <= shift, pulse rx_valid on the next cycle and go to IDLE.
REQ-020 STOP sample = 0: SHALL pulse rx_err on the next cycle, leave rx_d unchanged and go to WAIT_IDLE.
REQ-021 WAIT_IDLE: SHALL stay until rx_s = 1, then enter IDLE; a held-low line (break) SHALL NOT start a new frame.
REQ-022 rx_valid and rx_err SHALL never be high together and SHALL each be high for exactly one cycle per frame.
REQ-023 Back-to-back frames: a falling edge on the cycle after the STOP sample SHALL be accepted; no idle gap is needed beyond the stop bit.
REQ-024 Latency: rx_valid SHALL rise 2 (synchronizer) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1) after the rx start-bit edge.
REQ-025 rx changes outside the sample points SHALL have no effect.
REQ-026 rx_valid and rx_err SHALL be registered outputs.

Reset
REQ-027 While rst = 1, SHALL force state = IDLE, counter = 0, bit index = 0, shift = 0, rx_d = 0x00, rx_valid = 0, rx_err = 0, rx_busy = 0 and synchronizer flops = 1.
REQ-028 rst asserted mid-frame SHALL abort the frame with no pulse and leave rx_d = 0x00.
REQ-029 After release, the receiver SHALL first accept a frame whose start edge occurs at least 2 cycles after deassertion.

Verification (CLKS_PER_BIT = 16 unless stated)
REQ-030 Frame 0x41 (bits 0,1,0,0,0,0,0,1,0,1) -> one rx_valid pulse, rx_d = 0x41, rx_err never high.
REQ-031 Frames 0x21 then 0x7E back-to-back with zero idle -> two rx_valid pulses carrying 0x21 then 0x7E, no rx_err.
REQ-032 rx low for 5 cycles, then high -> no pulse, rx_busy high for at most 8 cycles, then IDLE.
REQ-033 Frame 0x55 with stop bit 0, line held low 40 cycles, then high -> one rx_err pulse, rx_d unchanged, no new frame until rx returns high.
REQ-034 rst pulsed during data bit 4 of 0xA5, then a clean 0x3C -> rx_d = 0x00 after reset, then one rx_valid pulse with rx_d = 0x3C.
REQ-035 CLKS_PER_BIT = 1085, frame 0x7E with a ±2% bit-time skew -> rx_d = 0x7E, rx_valid pulse.
